// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//   EX/MEM pipeline register with valid bit, stall (hold), flush (bubble),
//   BEQ/BNE branch sense and a registered branch-taken decision. Two
//   saturating event counters (stalls, flushes) feed the debug path.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   iStall / iFlush   : hold stage / load bubble (flush wins over stall)
//   iValid, i<ctrl>   : EX-stage valid and control bits
//   iBranchNe, iZFlag : branch sense (0=BEQ, 1=BNE) and ALU zero flag
//   iBranchResult, iAluRes, iData2, iRegDestMux : datapath fields
//   o*                : registered copies of the above
//   oBranchTaken      : captured instruction is a taken branch
//   oStallCount, oFlushCount : saturating event counters
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iStall,
  input  logic                  iFlush,
  input  logic                  iValid,
  input  logic                  iRegWrite,
  input  logic                  iMemToReg,
  input  logic                  iMemWrite,
  input  logic                  iMemRead,
  input  logic                  iMemBranch,
  input  logic                  iBranchNe,
  input  logic [DATA_W-1:0]     iBranchResult,
  input  logic                  iZFlag,
  input  logic [DATA_W-1:0]     iAluRes,
  input  logic [DATA_W-1:0]     iData2,
  input  logic [REG_ADDR_W-1:0] iRegDestMux,
  output logic                  oValid,
  output logic                  oRegWrite,
  output logic                  oMemToReg,
  output logic                  oMemWrite,
  output logic                  oMemRead,
  output logic                  oMemBranch,
  output logic                  oBranchNe,
  output logic                  oZFlag,
  output logic [DATA_W-1:0]     oBranchResult,
  output logic [DATA_W-1:0]     oAluRes,
  output logic [DATA_W-1:0]     oData2,
  output logic [REG_ADDR_W-1:0] oRegDestMux,
  output logic                  oBranchTaken,
  output logic [CNT_W-1:0]      oStallCount,
  output logic [CNT_W-1:0]      oFlushCount
);

  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic                  memToReg;
    logic                  memWrite;
    logic                  memRead;
    logic                  memBranch;
    logic                  branchNe;
    logic                  zFlag;
    logic                  branchTaken;
    logic [DATA_W-1:0]     branchResult;
    logic [DATA_W-1:0]     aluRes;
    logic [DATA_W-1:0]     data2;
    logic [REG_ADDR_W-1:0] regDest;
  } stage_t;

  // Per-cycle mode; there is no multi-cycle state, so this is pure decode.
  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_BUBBLE = 2'd2
  } mode_t;

  mode_t             mode;
  stage_t            stageQ, stageD;
  logic [CNT_W-1:0]  stallCnt, flushCnt;

  always_comb begin
    mode = MODE_LOAD;
    if (iFlush)      mode = MODE_BUBBLE;
    else if (iStall) mode = MODE_HOLD;
  end

  always_comb begin
    stageD = stageQ;
    unique case (mode)
      MODE_BUBBLE: stageD = '0;
      MODE_HOLD:   stageD = stageQ;
      default: begin
        stageD.valid        = iValid;
        // Side-effecting controls are gated so an invalid slot never writes.
        stageD.regWrite     = iRegWrite  & iValid;
        stageD.memToReg     = iMemToReg;
        stageD.memWrite     = iMemWrite  & iValid;
        stageD.memRead      = iMemRead   & iValid;
        stageD.memBranch    = iMemBranch & iValid;
        stageD.branchNe     = iBranchNe;
        stageD.zFlag        = iZFlag;
        // BEQ taken on Z=1, BNE taken on Z=0.
        stageD.branchTaken  = iValid & iMemBranch & (iZFlag ^ iBranchNe);
        stageD.branchResult = iBranchResult;
        stageD.aluRes       = iAluRes;
        stageD.data2        = iData2;
        stageD.regDest      = iRegDestMux;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageQ   <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      stageQ <= stageD;
      if (mode == MODE_HOLD && stallCnt != '1)   stallCnt <= stallCnt + 1'b1;
      if (mode == MODE_BUBBLE && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign oValid        = stageQ.valid;
  assign oRegWrite     = stageQ.regWrite;
  assign oMemToReg     = stageQ.memToReg;
  assign oMemWrite     = stageQ.memWrite;
  assign oMemRead      = stageQ.memRead;
  assign oMemBranch    = stageQ.memBranch;
  assign oBranchNe     = stageQ.branchNe;
  assign oZFlag        = stageQ.zFlag;
  assign oBranchTaken  = stageQ.branchTaken;
  assign oBranchResult = stageQ.branchResult;
  assign oAluRes       = stageQ.aluRes;
  assign oData2        = stageQ.data2;
  assign oRegDestMux   = stageQ.regDest;
  assign oStallCount   = stallCnt;
  assign oFlushCount   = flushCnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
module tb_ex_mem_pipe_reg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, iStall, iFlush, iValid, iRegWrite, iMemToReg, iMemWrite, iMemRead;
  logic iMemBranch, iBranchNe, iZFlag;
  logic [DW-1:0] iBranchResult, iAluRes, iData2;
  logic [RW-1:0] iRegDestMux;
  logic oValid, oRegWrite, oMemToReg, oMemWrite, oMemRead, oMemBranch, oBranchNe, oZFlag, oBranchTaken;
  logic [DW-1:0] oBranchResult, oAluRes, oData2;
  logic [RW-1:0] oRegDestMux;
  logic [CW-1:0] oStallCount, oFlushCount;

  int nAsserts = 0;
  int nFails   = 0;

  // Reference model state (expected register contents).
  logic mValid, mRegWrite, mMemToReg, mMemWrite, mMemRead, mMemBranch, mBranchNe, mZFlag, mTaken;
  logic [DW-1:0] mBranchResult, mAluRes, mData2;
  logic [RW-1:0] mRegDest;
  int mStalls, mFlushes;

  ex_mem_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iRegWrite(iRegWrite), .iMemToReg(iMemToReg), .iMemWrite(iMemWrite),
    .iMemRead(iMemRead), .iMemBranch(iMemBranch), .iBranchNe(iBranchNe),
    .iBranchResult(iBranchResult), .iZFlag(iZFlag), .iAluRes(iAluRes),
    .iData2(iData2), .iRegDestMux(iRegDestMux),
    .oValid(oValid), .oRegWrite(oRegWrite), .oMemToReg(oMemToReg),
    .oMemWrite(oMemWrite), .oMemRead(oMemRead), .oMemBranch(oMemBranch),
    .oBranchNe(oBranchNe), .oZFlag(oZFlag), .oBranchResult(oBranchResult),
    .oAluRes(oAluRes), .oData2(oData2), .oRegDestMux(oRegDestMux),
    .oBranchTaken(oBranchTaken), .oStallCount(oStallCount), .oFlushCount(oFlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearStage();
    mValid = 0; mRegWrite = 0; mMemToReg = 0; mMemWrite = 0; mMemRead = 0;
    mMemBranch = 0; mBranchNe = 0; mZFlag = 0; mTaken = 0;
    mBranchResult = '0; mAluRes = '0; mData2 = '0; mRegDest = '0;
  endtask

  task automatic clearInputs();
    rst = 0; iStall = 0; iFlush = 0; iValid = 0; iRegWrite = 0; iMemToReg = 0;
    iMemWrite = 0; iMemRead = 0; iMemBranch = 0; iBranchNe = 0; iZFlag = 0;
    iBranchResult = '0; iAluRes = '0; iData2 = '0; iRegDestMux = '0;
  endtask

  // Expected effect of one rising edge, from the stage rules.
  task automatic modelEdge();
    if (rst) begin
      clearStage();
      mStalls = 0; mFlushes = 0;
    end else if (iFlush) begin
      clearStage();
      if (mFlushes < CMAX) mFlushes++;
    end else if (iStall) begin
      if (mStalls < CMAX) mStalls++;
    end else begin
      mValid = iValid;
      mRegWrite = iRegWrite && iValid;
      mMemToReg = iMemToReg;
      mMemWrite = iMemWrite && iValid;
      mMemRead = iMemRead && iValid;
      mMemBranch = iMemBranch && iValid;
      mBranchNe = iBranchNe;
      mZFlag = iZFlag;
      mTaken = iValid && iMemBranch && (iZFlag != iBranchNe);
      mBranchResult = iBranchResult; mAluRes = iAluRes; mData2 = iData2;
      mRegDest = iRegDestMux;
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".valid"}, DW'(oValid), DW'(mValid));
    chk({tag, ".regWrite"}, DW'(oRegWrite), DW'(mRegWrite));
    chk({tag, ".memToReg"}, DW'(oMemToReg), DW'(mMemToReg));
    chk({tag, ".memWrite"}, DW'(oMemWrite), DW'(mMemWrite));
    chk({tag, ".memRead"}, DW'(oMemRead), DW'(mMemRead));
    chk({tag, ".memBranch"}, DW'(oMemBranch), DW'(mMemBranch));
    chk({tag, ".branchNe"}, DW'(oBranchNe), DW'(mBranchNe));
    chk({tag, ".zFlag"}, DW'(oZFlag), DW'(mZFlag));
    chk({tag, ".taken"}, DW'(oBranchTaken), DW'(mTaken));
    chk({tag, ".branchResult"}, oBranchResult, mBranchResult);
    chk({tag, ".aluRes"}, oAluRes, mAluRes);
    chk({tag, ".data2"}, oData2, mData2);
    chk({tag, ".regDest"}, DW'(oRegDestMux), DW'(mRegDest));
    chk({tag, ".stallCnt"}, DW'(oStallCount), DW'(mStalls));
    chk({tag, ".flushCnt"}, DW'(oFlushCount), DW'(mFlushes));
  endtask

  task automatic cycle(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    clearInputs();
    clearStage();
    mStalls = 0; mFlushes = 0;

    // 1. reset with all inputs nonzero, then a load
    rst = 1; iStall = 1; iFlush = 1; iValid = 1; iRegWrite = 1; iMemToReg = 1;
    iMemWrite = 1; iMemRead = 1; iMemBranch = 1; iBranchNe = 1; iZFlag = 1;
    iBranchResult = 32'hFFFF_FFFF; iAluRes = 32'hDEAD_BEEF; iData2 = 32'h1234_5678;
    iRegDestMux = 5'd31;
    cycle("rst0");
    cycle("rst1");
    chk("rst.aluRes", oAluRes, 32'h0);
    chk("rst.stallCnt", DW'(oStallCount), 32'h0);
    clearInputs();
    iValid = 1; iAluRes = 32'h0000_1234; iRegDestMux = 5'd9; iRegWrite = 1;
    cycle("load");
    chk("load.aluRes", oAluRes, 32'h1234);
    chk("load.regDest", DW'(oRegDestMux), 32'd9);
    chk("load.regWrite", DW'(oRegWrite), 32'd1);
    chk("load.valid", DW'(oValid), 32'd1);

    // 2. branch sense
    clearInputs();
    iValid = 1; iMemBranch = 1; iZFlag = 1; iBranchNe = 0; iBranchResult = 32'h40;
    cycle("beqT");
    chk("beqT.taken", DW'(oBranchTaken), 32'd1);
    chk("beqT.target", oBranchResult, 32'h40);
    iBranchNe = 1;
    cycle("bneN");
    chk("bneN.taken", DW'(oBranchTaken), 32'd0);
    iZFlag = 0;
    cycle("bneT");
    chk("bneT.taken", DW'(oBranchTaken), 32'd1);

    // 3. stall hold
    clearInputs();
    iValid = 1; iAluRes = 32'hAA;
    cycle("preStall");
    iStall = 1; iAluRes = 32'h55;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.aluRes", oAluRes, 32'hAA);
    end
    chk("stall.cnt", DW'(oStallCount), 32'd3);
    iStall = 0;
    cycle("unstall");
    chk("unstall.aluRes", oAluRes, 32'h55);

    // 4. flush beats stall
    clearInputs();
    iValid = 1; iMemWrite = 1; iAluRes = 32'h100; iData2 = 32'h77; iFlush = 1; iStall = 1;
    cycle("flush");
    chk("flush.valid", DW'(oValid), 32'd0);
    chk("flush.memWrite", DW'(oMemWrite), 32'd0);
    chk("flush.data2", oData2, 32'd0);
    chk("flush.flushCnt", DW'(oFlushCount), 32'd1);
    chk("flush.stallCnt", DW'(oStallCount), 32'd3);

    // 5. invalid gating
    clearInputs();
    iValid = 0; iRegWrite = 1; iMemWrite = 1; iMemBranch = 1; iZFlag = 1; iAluRes = 32'hCAFE;
    cycle("inval");
    chk("inval.regWrite", DW'(oRegWrite), 32'd0);
    chk("inval.memBranch", DW'(oMemBranch), 32'd0);
    chk("inval.taken", DW'(oBranchTaken), 32'd0);
    chk("inval.aluRes", oAluRes, 32'hCAFE);

    // 6. saturation, then reset while stalled
    clearInputs();
    iStall = 1; iAluRes = 32'h9;
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat.cnt", DW'(oStallCount), 32'd15);
    rst = 1;
    cycle("rstStall");
    chk("rstStall.cnt", DW'(oStallCount), 32'd0);
    chk("rstStall.aluRes", oAluRes, 32'd0);

    // Random traffic against the model.
    clearInputs();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      iFlush = ($urandom_range(0, 99) < 12);
      iStall = ($urandom_range(0, 99) < 25);
      iValid = $urandom_range(0, 3) != 0;
      iRegWrite = 1'($urandom); iMemToReg = 1'($urandom); iMemWrite = 1'($urandom);
      iMemRead = 1'($urandom); iMemBranch = 1'($urandom); iBranchNe = 1'($urandom);
      iZFlag = 1'($urandom);
      iBranchResult = $urandom; iAluRes = $urandom; iData2 = $urandom;
      iRegDestMux = 5'($urandom);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
